// File: rtl/frame_deserializer.sv
// Byte-stream to command deserializer: NUM_OPERANDS operands (LSB first) then one opcode byte, held until acked.
// Optional idle-gap timeout inside a frame is enabled with `define FRAME_TIMEOUT_EN.
module frame_deserializer #(
    parameter int DATA_W         = 8,
    parameter int NUM_OPERANDS   = 2,
    parameter int OPERAND_BYTES  = 1,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                                          i_clk,
    input  logic                                          reset,
    input  logic                                          i_valid,
    input  logic [DATA_W-1:0]                             i_data,
    output logic                                          o_ready,
    output logic                                          o_frame_valid,
    input  logic                                          i_frame_ack,
    output logic [NUM_OPERANDS*OPERAND_BYTES*DATA_W-1:0]  o_operands,
    output logic [DATA_W-1:0]                             o_opcode,
    output logic                                          o_overrun,
    output logic                                          o_timeout
);

    localparam int NB        = NUM_OPERANDS * OPERAND_BYTES;
    localparam int FRAME_LEN = NB + 1;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    if (NUM_OPERANDS < 1 || OPERAND_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("frame_deserializer: NUM_OPERANDS, OPERAND_BYTES and TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;

    assign o_ready       = (state != S_HOLD);
    assign o_frame_valid = (state == S_HOLD);

`ifdef FRAME_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    logic [GAP_W-1:0] gap;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            o_operands <= '0;
            o_opcode   <= '0;
            o_overrun  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            gap        <= '0;
            o_timeout  <= 1'b0;
`endif
        end else begin
`ifdef FRAME_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        o_operands[DATA_W-1:0] <= i_data;
                        idx   <= IDX_W'(1);
                        state <= S_COLLECT;
`ifdef FRAME_TIMEOUT_EN
                        gap   <= '0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (i_valid) begin
`ifdef FRAME_TIMEOUT_EN
                        gap <= '0;
`endif
                        if (idx == LAST_IDX) begin
                            o_opcode <= i_data;
                            idx      <= '0;
                            state    <= S_HOLD;
                        end else begin
                            // flat byte offset equals operand*OPERAND_BYTES + lane
                            for (int b = 1; b < NB; b++) begin
                                if (idx == IDX_W'(b))
                                    o_operands[b*DATA_W +: DATA_W] <= i_data;
                            end
                            idx <= idx + IDX_W'(1);
                        end
                    end
`ifdef FRAME_TIMEOUT_EN
                    else if (gap == GAP_LAST) begin
                        gap       <= '0;
                        idx       <= '0;
                        o_timeout <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (i_valid)
                        o_overrun <= 1'b1;
                    if (i_frame_ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: directed scenarios plus randomized frames against a byte-list model.
module tb_frame_deserializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        ack = 1'b0;
    logic        ready, fv, overrun, tmo;
    logic [15:0] ops;
    logic [7:0]  opc;

    logic        valid2 = 1'b0;
    logic [7:0]  data2 = 8'h00;
    logic        ack2 = 1'b0;
    logic        ready2, fv2, overrun2, tmo2;
    logic [47:0] ops2;
    logic [7:0]  opc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_deserializer #(.DATA_W(8), .NUM_OPERANDS(2), .OPERAND_BYTES(1), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .reset(reset), .i_valid(valid), .i_data(data), .o_ready(ready),
        .o_frame_valid(fv), .i_frame_ack(ack), .o_operands(ops), .o_opcode(opc),
        .o_overrun(overrun), .o_timeout(tmo)
    );

    frame_deserializer #(.DATA_W(8), .NUM_OPERANDS(3), .OPERAND_BYTES(2), .TIMEOUT_CYCLES(8)) dut_wide (
        .i_clk(clk), .reset(reset), .i_valid(valid2), .i_data(data2), .o_ready(ready2),
        .o_frame_valid(fv2), .i_frame_ack(ack2), .o_operands(ops2), .o_opcode(opc2),
        .o_overrun(overrun2), .o_timeout(tmo2)
    );

    // All tasks start and end at a negedge; inputs change there, outputs are sampled there.
    task automatic send_byte(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++;
        if ({ready, fv, overrun, tmo} !== 4'b1000 || ops !== 16'h0 || opc !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b fv=%b ovr=%b tmo=%b ops=%h opc=%h, want 1 0 0 0 0000 00",
                     ready, fv, overrun, tmo, ops, opc);
        end
        checks++;
        if (ready2 !== 1'b1 || fv2 !== 1'b0 || ops2 !== 48'h0 || opc2 !== 8'h0) begin
            errors++;
            $display("FAIL reset_state_wide: ready=%b fv=%b ops=%h opc=%h", ready2, fv2, ops2, opc2);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h05);
        checks++;
        if (fv !== 1'b1 || ready !== 1'b0 || ops !== 16'h3412 || opc !== 8'h05) begin
            errors++;
            $display("FAIL basic_frame: fv=%b ready=%b ops=%h opc=%h, want 1 0 3412 05", fv, ready, ops, opc);
        end
        do_ack();
        checks++;
        if (fv !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack: fv=%b ready=%b, want 0 1", fv, ready);
        end
    endtask

    task automatic test_wide();
        logic [7:0] seq [7];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hA0};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ready2 !== 1'b1) begin
                errors++;
                $display("FAIL wide_ready byte %0d: ready=%b, want 1", i, ready2);
            end
            valid2 = 1'b1;
            data2  = seq[i];
            @(negedge clk);
            valid2 = 1'b0;
        end
        checks++;
        if (fv2 !== 1'b1 || ops2 !== 48'h060504030201 || opc2 !== 8'hA0) begin
            errors++;
            $display("FAIL wide_frame: fv=%b ops=%h opc=%h, want 1 060504030201 a0", fv2, ops2, opc2);
        end
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
        checks++;
        if (fv2 !== 1'b0 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL wide_ack: fv=%b ready=%b, want 0 1", fv2, ready2);
        end
    endtask

    task automatic test_random();
        logic [7:0]  frame [3];
        logic [15:0] exp_ops;
        int w;
        int bad = 0;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 3; i++) frame[i] = 8'($urandom);
            exp_ops = (16'(frame[1]) << 8) | 16'(frame[0]);
            for (int i = 0; i < 3; i++) begin
                idle($urandom_range(0, 5));
                send_byte(frame[i]);
            end
            w = 0;
            while (fv !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (fv !== 1'b1 || ops !== exp_ops || opc !== frame[2]) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_frame %0d: fv=%b ops=%h opc=%h, want 1 %h %h",
                             f, fv, ops, opc, exp_ops, frame[2]);
            end
            idle($urandom_range(0, 3));
            checks++;
            if (fv !== 1'b1 || ops !== exp_ops) begin
                errors++;
                $display("FAIL random_hold %0d: fv=%b ops=%h, want 1 %h", f, fv, ops, exp_ops);
            end
            do_ack();
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL random_overrun: ovr=%b, want 0", overrun);
        end
    endtask

    task automatic test_overrun();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        idle(5);
        checks++;
        if (fv !== 1'b1 || ops !== 16'hBBAA || opc !== 8'hCC) begin
            errors++;
            $display("FAIL hold_stable: fv=%b ops=%h opc=%h, want 1 bbaa cc", fv, ops, opc);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready: ready=%b, want 0", ready);
        end
        send_byte(8'h77);
        checks++;
        if (overrun !== 1'b1 || fv !== 1'b1 || ops !== 16'hBBAA || opc !== 8'hCC) begin
            errors++;
            $display("FAIL overrun: ovr=%b fv=%b ops=%h opc=%h, want 1 1 bbaa cc", overrun, fv, ops, opc);
        end
        do_ack();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        checks++;
        if (fv !== 1'b1 || ops !== 16'h0201 || opc !== 8'h03 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL after_overrun: fv=%b ops=%h opc=%h ovr=%b, want 1 0201 03 1", fv, ops, opc, overrun);
        end
        do_ack();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h9C);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checks++;
        if (ops !== 16'h0 || opc !== 8'h0 || fv !== 1'b0 || overrun !== 1'b0 || tmo !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe: ops=%h opc=%h fv=%b ovr=%b tmo=%b ready=%b, want 0000 00 0 0 0 1",
                     ops, opc, fv, overrun, tmo, ready);
        end
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        checks++;
        if (fv !== 1'b1 || ops !== 16'h5544 || opc !== 8'h66) begin
            errors++;
            $display("FAIL post_reset_frame: fv=%b ops=%h opc=%h, want 1 5544 66", fv, ops, opc);
        end
        do_ack();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        send_byte(8'h55);
        for (int i = 0; i < 12; i++) begin
            if (tmo === 1'b1) pulses++;
            @(negedge clk);
        end
`ifdef FRAME_TIMEOUT_EN
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL timeout_pulse: pulses=%0d, want 1", pulses);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        checks++;
        if (fv !== 1'b1 || ops !== 16'h0201 || opc !== 8'h03) begin
            errors++;
            $display("FAIL timeout_next_frame: fv=%b ops=%h opc=%h, want 1 0201 03", fv, ops, opc);
        end
`else
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL no_timeout: pulses=%0d, want 0", pulses);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        checks++;
        if (fv !== 1'b1 || ops !== 16'h0155 || opc !== 8'h02) begin
            errors++;
            $display("FAIL gap_frame: fv=%b ops=%h opc=%h, want 1 0155 02", fv, ops, opc);
        end
`endif
        do_ack();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_wide();
        test_random();
        test_overrun();
        test_reset_midframe();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
